// File: rtl/il_xbar_pkg.sv
// rtl/il_xbar_pkg.sv - shared constants and address helpers for the interleaved bank crossbar
package il_xbar_pkg;

    localparam logic [31:0] ERR_RDATA = 32'hBADC_0DE5;

    // off is the address already rebased to the start of the interleaved region
    function automatic logic [31:0] bank_idx(input logic [31:0] off, input int gran_log2,
                                             input int bank_log2);
        logic [31:0] mask;
        mask = (32'd1 << bank_log2) - 32'd1;
        return (off >> gran_log2) & mask;
    endfunction

    function automatic logic [31:0] bank_local_addr(input logic [31:0] off, input int gran_log2,
                                                    input int bank_log2);
        logic [31:0] low_mask;
        low_mask = (32'd1 << gran_log2) - 32'd1;
        return ((off >> (gran_log2 + bank_log2)) << gran_log2) | (off & low_mask);
    endfunction

endpackage

// File: rtl/il_tag_fifo.sv
// rtl/il_tag_fifo.sv - in-order master-id FIFO tracking outstanding requests of one bank
module il_tag_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data;
    end

endmodule

// File: rtl/il_bank_xbar.sv
// rtl/il_bank_xbar.sv - N-master x M-bank interleaved crossbar with round-robin banks,
// in-order tag FIFOs, out-of-range error responses and per-bank conflict counters
module il_bank_xbar
    import il_xbar_pkg::*;
#(
    parameter int          NUM_MASTER     = 4,
    parameter int          NUM_BANK       = 4,
    parameter int          IL_GRAN_LOG2   = 2,
    parameter logic [31:0] IL_ADDR_OFFSET = 32'h0000_8000,
    parameter logic [31:0] IL_ADDR_SIZE   = 32'h0002_0000,
    parameter int          BANK_OUTST     = 2,
    parameter int          CNT_W          = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_MASTER-1:0]     m_req_i,
    input  logic [NUM_MASTER-1:0]     m_we_i,
    input  logic [NUM_MASTER*4-1:0]   m_be_i,
    input  logic [NUM_MASTER*32-1:0]  m_addr_i,
    input  logic [NUM_MASTER*32-1:0]  m_wdata_i,
    output logic [NUM_MASTER-1:0]     m_gnt_o,
    output logic [NUM_MASTER-1:0]     m_rvalid_o,
    output logic [NUM_MASTER*32-1:0]  m_rdata_o,
    output logic [NUM_MASTER-1:0]     m_err_o,
    output logic [NUM_BANK-1:0]       b_req_o,
    output logic [NUM_BANK-1:0]       b_we_o,
    output logic [NUM_BANK*4-1:0]     b_be_o,
    output logic [NUM_BANK*32-1:0]    b_addr_o,
    output logic [NUM_BANK*32-1:0]    b_wdata_o,
    input  logic [NUM_BANK-1:0]       b_gnt_i,
    input  logic [NUM_BANK-1:0]       b_rvalid_i,
    input  logic [NUM_BANK*32-1:0]    b_rdata_i,
    input  logic                      cnt_clr_i,
    output logic [NUM_BANK*CNT_W-1:0] conflict_cnt_o
);
    localparam int BANK_W = $clog2(NUM_BANK);
    localparam int TAG_W  = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;

    logic [NUM_MASTER-1:0]                busy_q, free, in_range, err_gnt;
    logic [BANK_W-1:0]                    m_bank  [NUM_MASTER];
    logic [31:0]                          m_laddr [NUM_MASTER];
    logic [NUM_BANK-1:0][NUM_MASTER-1:0]  cand;
    logic [TAG_W-1:0]                     ptr_q   [NUM_BANK];
    logic [TAG_W-1:0]                     winner  [NUM_BANK];
    logic [TAG_W-1:0]                     fifo_head [NUM_BANK];
    logic [NUM_BANK-1:0]                  has_cand, conflict, fifo_full, fifo_empty;
    logic [NUM_BANK-1:0]                  b_hs, b_pop, seen_gnt_q;
    logic [CNT_W-1:0]                     cnt_q   [NUM_BANK];
    logic [NUM_MASTER-1:0]                rvalid_q, err_q, rvalid_d, err_d;
    logic [31:0]                          rdata_q [NUM_MASTER];
    logic [31:0]                          rdata_d [NUM_MASTER];

    // A master whose response is being delivered this cycle may issue again immediately
    assign free    = ~busy_q | rvalid_q;
    assign err_gnt = m_req_i & free & ~in_range & {NUM_MASTER{~rst_i}};

    always_comb begin
        logic [31:0] addr, off, bsel;
        addr = '0;
        off  = '0;
        bsel = '0;
        for (int m = 0; m < NUM_MASTER; m++) begin
            addr        = m_addr_i[m*32 +: 32];
            off         = addr - IL_ADDR_OFFSET;
            in_range[m] = (addr >= IL_ADDR_OFFSET) && (off < IL_ADDR_SIZE);
            bsel        = bank_idx(off, IL_GRAN_LOG2, BANK_W);
            m_bank[m]   = bsel[BANK_W-1:0];
            m_laddr[m]  = bank_local_addr(off, IL_GRAN_LOG2, BANK_W);
        end
    end

    always_comb begin
        int   idx, ncand;
        logic found;
        idx   = 0;
        ncand = 0;
        found = 1'b0;
        cand  = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int m = 0; m < NUM_MASTER; m++) begin
                cand[b][m] = m_req_i[m] && free[m] && in_range[m] && (m_bank[m] == BANK_W'(b));
            end
        end
        for (int b = 0; b < NUM_BANK; b++) begin
            winner[b] = '0;
            found     = 1'b0;
            ncand     = 0;
            for (int i = 0; i < NUM_MASTER; i++) begin
                idx = int'(ptr_q[b]) + i;
                if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
                if (!found && cand[b][idx]) begin
                    found     = 1'b1;
                    winner[b] = TAG_W'(idx);
                end
                if (cand[b][i]) ncand = ncand + 1;
            end
            has_cand[b] = found;
            conflict[b] = (ncand >= 2);
        end
    end

    always_comb begin
        int w;
        w         = 0;
        b_hs      = '0;
        b_req_o   = '0;
        b_we_o    = '0;
        b_be_o    = '0;
        b_addr_o  = '0;
        b_wdata_o = '0;
        m_gnt_o   = err_gnt;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (has_cand[b] && !fifo_full[b] && !rst_i) begin
                w                    = int'(winner[b]);
                b_req_o[b]           = 1'b1;
                b_we_o[b]            = m_we_i[w];
                b_be_o[b*4 +: 4]     = m_be_i[w*4 +: 4];
                b_addr_o[b*32 +: 32] = m_laddr[w];
                b_wdata_o[b*32 +: 32] = m_wdata_i[w*32 +: 32];
                if (b_gnt_i[b]) begin
                    b_hs[b]    = 1'b1;
                    m_gnt_o[w] = 1'b1;
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        il_tag_fifo #(
            .DEPTH (BANK_OUTST),
            .WIDTH (TAG_W)
        ) u_tag_fifo (
            .clk       (clk_i),
            .rst       (rst_i),
            .push      (b_hs[b]),
            .push_data (winner[b]),
            .pop       (b_rvalid_i[b]),
            .head      (fifo_head[b]),
            .full      (fifo_full[b]),
            .empty     (fifo_empty[b])
        );

        assign b_pop[b] = b_rvalid_i[b] && !fifo_empty[b];

        // Pulses before the first post-reset grant drain traffic discarded by reset
        a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
            !(b_rvalid_i[b] && fifo_empty[b] && seen_gnt_q[b]));
    end

    always_comb begin
        rvalid_d = '0;
        err_d    = '0;
        for (int m = 0; m < NUM_MASTER; m++) rdata_d[m] = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            for (int m = 0; m < NUM_MASTER; m++) begin
                if (b_pop[b] && (fifo_head[b] == TAG_W'(m))) begin
                    rvalid_d[m] = 1'b1;
                    rdata_d[m]  = b_rdata_i[b*32 +: 32];
                end
            end
        end
        for (int m = 0; m < NUM_MASTER; m++) begin
            if (err_gnt[m]) begin
                rvalid_d[m] = 1'b1;
                err_d[m]    = 1'b1;
                rdata_d[m]  = ERR_RDATA;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            rvalid_q   <= '0;
            err_q      <= '0;
            seen_gnt_q <= '0;
            for (int m = 0; m < NUM_MASTER; m++) rdata_q[m] <= '0;
            for (int b = 0; b < NUM_BANK; b++) begin
                ptr_q[b] <= '0;
                cnt_q[b] <= '0;
            end
        end else begin
            busy_q     <= (busy_q & ~rvalid_q) | m_gnt_o;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            seen_gnt_q <= seen_gnt_q | b_hs;
            for (int m = 0; m < NUM_MASTER; m++) rdata_q[m] <= rdata_d[m];
            for (int b = 0; b < NUM_BANK; b++) begin
                if (b_hs[b]) begin
                    ptr_q[b] <= (int'(winner[b]) == NUM_MASTER - 1) ? '0 : winner[b] + 1'b1;
                end
                if (cnt_clr_i) begin
                    cnt_q[b] <= '0;
                end else if (conflict[b] && (cnt_q[b] != '1)) begin
                    cnt_q[b] <= cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign m_rvalid_o = rvalid_q;
    assign m_err_o    = err_q;

    always_comb begin
        for (int m = 0; m < NUM_MASTER; m++) m_rdata_o[m*32 +: 32] = rdata_q[m];
        for (int b = 0; b < NUM_BANK; b++) conflict_cnt_o[b*CNT_W +: CNT_W] = cnt_q[b];
    end

endmodule

// File: doc/il_bank_xbar.md
Name: il_bank_xbar

Overview:
- Parametrised N-master x M-bank interleaved crossbar for the compute-unit local memory; successor to the fixed 4x4 word-interleaved crossbar.
- Adds a configurable interleave granularity, per-bank round-robin arbitration and per-bank in-order tag FIFOs, so bank read latency can vary.
- Out-of-range accesses return an error response instead of being steered to a default bank.
- Adds per-bank conflict counters for profiling.

Parameters:
- NUM_MASTER, 4, number of requesting ports (>=1).
- NUM_BANK, 4, number of banks (power of two, >=2).
- IL_GRAN_LOG2, 2, log2 of interleave granule in bytes (2 = word, 4 = 16 B).
- IL_ADDR_OFFSET, 32'h00008000, base address of the interleaved region.
- IL_ADDR_SIZE, 32'h00020000, region size in bytes (power of two, multiple of NUM_BANK << IL_GRAN_LOG2).
- BANK_OUTST, 2, maximum outstanding requests per bank (tag FIFO depth, >=1).
- CNT_W, 16, conflict counter width.

Ports:
- clk_i in 1: clock.
- rst_i in 1: synchronous active-high reset.
- m_req_i in NUM_MASTER: request valid.
- m_we_i in NUM_MASTER: write enable.
- m_be_i in NUM_MASTER*4: byte enables.
- m_addr_i in NUM_MASTER*32: byte address.
- m_wdata_i in NUM_MASTER*32: write data.
- m_gnt_o out NUM_MASTER: request accepted this cycle.
- m_rvalid_o out NUM_MASTER: response valid.
- m_rdata_o out NUM_MASTER*32: read data.
- m_err_o out NUM_MASTER: response is an error (qualified by m_rvalid_o).
- b_req_o out NUM_BANK: bank request.
- b_we_o out NUM_BANK: bank write enable.
- b_be_o out NUM_BANK*4: bank byte enables.
- b_addr_o out NUM_BANK*32: bank-local byte address.
- b_wdata_o out NUM_BANK*32: bank write data.
- b_gnt_i in NUM_BANK: bank accepted request.
- b_rvalid_i in NUM_BANK: bank response valid (in order per bank, >=1 cycle after grant).
- b_rdata_i in NUM_BANK*32: bank read data.
- cnt_clr_i in 1: synchronous clear of all conflict counters.
- conflict_cnt_o out NUM_BANK*CNT_W: per-bank conflict counts.

Behaviour:
- Decode:
  - off = addr - IL_ADDR_OFFSET, computed unsigned, 32 bit.
  - In range iff addr >= IL_ADDR_OFFSET and off < IL_ADDR_SIZE.
  - bank = off[IL_GRAN_LOG2 +: log2(NUM_BANK)].
  - Bank-local address = {off[31:IL_GRAN_LOG2+log2(NUM_BANK)], off[IL_GRAN_LOG2-1:0]}, zero-extended to 32 bits.
- Outstanding rule:
  - Each master has at most one transaction in flight, tracked by a per-master busy flag.
  - m_gnt_o is never asserted while busy, except in the same cycle that master's m_rvalid_o is asserted; busy is then cleared and set again by the new grant.
- Arbitration, per bank:
  - Candidates are in-range masters that are not busy and address this bank.
  - Round-robin pointer: highest priority is the pointer index, then ascending with wrap.
  - b_req_o is asserted only when a candidate exists and the tag FIFO is not full. Winner's fields are driven combinationally.
  - On b_req_o & b_gnt_i: m_gnt_o[winner] = 1, winner's id is pushed into the tag FIFO, pointer <= winner+1 (mod NUM_MASTER), busy[winner] set.
  - No handshake: pointer and FIFO are unchanged. Losers see m_gnt_o = 0 and keep their request stable.
- Response path:
  - On b_rvalid_i: pop tag FIFO head. Next cycle the addressed master sees m_rvalid_o = 1, m_rdata_o = registered b_rdata_i, m_err_o = 0.
  - Response latency is bank latency + 1.
  - Push and pop in the same cycle are allowed; a full FIFO that pops in a cycle still refuses a push that cycle.
  - b_rvalid_i with an empty FIFO is a protocol violation; assert in simulation and ignore in RTL.
- Error path:
  - An out-of-range, non-busy request is granted in the same cycle without touching any bank.
  - Next cycle: m_rvalid_o = 1, m_err_o = 1, m_rdata_o = 32'hBADC0DE5. Writes are dropped.
- Conflict counter:
  - Increments in each cycle where >=2 candidates target the bank.
  - Saturates at all-ones.
  - cnt_clr_i has priority over increment.
- Reset: all outputs 0; busy flags, FIFOs, pointers and counters cleared. In-flight transactions are discarded and bank responses still pending are dropped, because their FIFOs are empty.

Decomposition:
- Package il_xbar_pkg: ERR_RDATA constant; function bank_idx(addr); function bank_local_addr(addr).
- Sub-module il_tag_fifo (depth BANK_OUTST, width log2(NUM_MASTER) with minimum 1), instantiated once per bank.
- Round-robin arbitration and response registers stay inline.

Test Plan:
- Single master, NUM_BANK=4, IL_GRAN_LOG2=2: read 0x8004 -> bank 1, b_addr_o=0x0; write 0x8014 -> bank 1, b_addr_o=0x4. With bank latency 1, m_rvalid_o arrives 2 cycles after grant.
- Masters 0 to 3 all read bank 2 continuously -> grants in order 0,1,2,3,0; conflict_cnt_o[2] increments each contested cycle; cnt_clr_i resets it to 0.
- IL_GRAN_LOG2=4: address 0x8010 maps to bank 1, 0x801C to bank 1 with b_addr_o=0xC, and 0x8040 to bank 0 with b_addr_o=0x10.
- Address 0x4000 and address 0x28000 -> granted immediately, next cycle m_err_o=1, m_rdata_o=0xBADC0DE5; no b_req_o asserted.
- BANK_OUTST=2, bank holds b_rvalid_i low: third master stalls with m_gnt_o=0 until the first pop, then is granted in that same pop cycle only if the FIFO was not full at the start of the cycle. Responses return in grant order.
- Assert rst_i with 2 transactions outstanding -> the next cycle shows all outputs 0; late b_rvalid_i pulses produce no m_rvalid_o.
